lc4_encoder: RTL and testbench

Streaming LC4 instruction encoder: accepts symbolic operation records (operation, register fields, 16-bit immediate) over a valid/ready handshake and emits packed 16-bit LC4 instruction words, one per output beat. It is the write-side counterpart of the instruction decoder and feeds the instruction-memory loader and the decoder's self-check bench. It range-checks immediates and expands the `LI` pseudo-op into one or two words.

---
 rtl/lc4_enc_pkg.sv | 57 +++++
 rtl/lc4_field_pack.sv | 113 +++++++++++
 rtl/lc4_encoder.sv | 106 ++++++++++
 tb/tb_lc4_encoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lc4_enc_pkg.sv
// LC4 encoder shared types: operation enum, opcode constants, immediate range helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc4_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_ADDI,
    OP_AND, OP_NOT, OP_OR, OP_XOR, OP_ANDI,
    OP_CMP, OP_CMPU, OP_CMPI, OP_CMPIU,
    OP_SLL, OP_SRA, OP_SRL, OP_MOD,
    OP_LDR, OP_STR, OP_BR, OP_NOP,
    OP_JSR, OP_JMP, OP_JSRR, OP_JMPR, OP_RTI,
    OP_CONST, OP_HICONST, OP_TRAP, OP_LI
  } op_t;

  // Primary opcodes, bits [15:12]
  localparam logic [3:0] OPC_BR      = 4'b0000;
  localparam logic [3:0] OPC_ARITH   = 4'b0001;
  localparam logic [3:0] OPC_CMP     = 4'b0010;
  localparam logic [3:0] OPC_LOGIC   = 4'b0101;
  localparam logic [3:0] OPC_LDR     = 4'b0110;
  localparam logic [3:0] OPC_STR     = 4'b0111;
  localparam logic [3:0] OPC_CONST   = 4'b1001;
  localparam logic [3:0] OPC_SHIFT   = 4'b1010;
  localparam logic [3:0] OPC_HICONST = 4'b1101;
  localparam logic [3:0] OPC_TRAP    = 4'b1111;

  // Jump-class opcodes, bits [15:11]
  localparam logic [4:0] OPC_JSR  = 5'b01001;
  localparam logic [4:0] OPC_JSRR = 5'b01000;
  localparam logic [4:0] OPC_JMP  = 5'b11001;
  localparam logic [4:0] OPC_JMPR = 5'b11000;

  localparam logic [15:0] INSN_RTI = 16'h8000;

  // Immediate field widths
  localparam int IMM5_W  = 5;
  localparam int IMM6_W  = 6;
  localparam int IMM7_W  = 7;
  localparam int IMM4_W  = 4;
  localparam int IMM8_W  = 8;
  localparam int IMM9_W  = 9;
  localparam int IMM11_W = 11;

  // True when v equals the sign-extension of its low n bits
  function automatic logic fits_signed(input logic [15:0] v, input int n);
    logic [15:0] hi;
    hi = 16'($signed(v) >>> (n - 1));
    return (hi == 16'h0000) || (hi == 16'hFFFF);
  endfunction

  // True when every bit above the low n bits is zero
  function automatic logic fits_unsigned(input logic [15:0] v, input int n);
    return (v >> n) == 16'h0000;
  endfunction

endpackage

// File: rtl/lc4_field_pack.sv
// Combinational LC4 field packer: (op, rd, rs, rt, imm) -> (insn, err).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller owns the handshake. LI yields its first (CONST) word.
module lc4_field_pack
  import lc4_enc_pkg::*;
(
  input  op_t         i_op,
  input  logic [2:0]  i_rd,
  input  logic [2:0]  i_rs,
  input  logic [2:0]  i_rt,
  input  logic [15:0] i_imm,
  output logic [15:0] o_insn,
  output logic        o_err
);

  // Pack fields per operation; out-of-range immediates keep their low bits and flag err
  always_comb begin
    o_insn = 16'h0000;
    o_err  = 1'b0;
    case (i_op)
      OP_ADD:  o_insn = {OPC_ARITH, i_rd, i_rs, 3'b000, i_rt};
      OP_MUL:  o_insn = {OPC_ARITH, i_rd, i_rs, 3'b001, i_rt};
      OP_SUB:  o_insn = {OPC_ARITH, i_rd, i_rs, 3'b010, i_rt};
      OP_DIV:  o_insn = {OPC_ARITH, i_rd, i_rs, 3'b011, i_rt};
      OP_ADDI: begin
        o_insn = {OPC_ARITH, i_rd, i_rs, 1'b1, i_imm[4:0]};
        o_err  = !fits_signed(i_imm, IMM5_W);
      end
      OP_AND:  o_insn = {OPC_LOGIC, i_rd, i_rs, 3'b000, i_rt};
      OP_NOT:  o_insn = {OPC_LOGIC, i_rd, i_rs, 3'b001, 3'b000};
      OP_OR:   o_insn = {OPC_LOGIC, i_rd, i_rs, 3'b010, i_rt};
      OP_XOR:  o_insn = {OPC_LOGIC, i_rd, i_rs, 3'b011, i_rt};
      OP_ANDI: begin
        o_insn = {OPC_LOGIC, i_rd, i_rs, 1'b1, i_imm[4:0]};
        o_err  = !fits_signed(i_imm, IMM5_W);
      end
      // Compares carry their first operand in the rd slot
      OP_CMP:  o_insn = {OPC_CMP, i_rs, 2'b00, 4'b0000, i_rt};
      OP_CMPU: o_insn = {OPC_CMP, i_rs, 2'b01, 4'b0000, i_rt};
      OP_CMPI: begin
        o_insn = {OPC_CMP, i_rs, 2'b10, i_imm[6:0]};
        o_err  = !fits_signed(i_imm, IMM7_W);
      end
      OP_CMPIU: begin
        o_insn = {OPC_CMP, i_rs, 2'b11, i_imm[6:0]};
        o_err  = !fits_unsigned(i_imm, IMM7_W);
      end
      OP_SLL: begin
        o_insn = {OPC_SHIFT, i_rd, i_rs, 2'b00, i_imm[3:0]};
        o_err  = !fits_unsigned(i_imm, IMM4_W);
      end
      OP_SRA: begin
        o_insn = {OPC_SHIFT, i_rd, i_rs, 2'b01, i_imm[3:0]};
        o_err  = !fits_unsigned(i_imm, IMM4_W);
      end
      OP_SRL: begin
        o_insn = {OPC_SHIFT, i_rd, i_rs, 2'b10, i_imm[3:0]};
        o_err  = !fits_unsigned(i_imm, IMM4_W);
      end
      OP_MOD:  o_insn = {OPC_SHIFT, i_rd, i_rs, 2'b11, 1'b0, i_rt};
      OP_LDR: begin
        o_insn = {OPC_LDR, i_rd, i_rs, i_imm[5:0]};
        o_err  = !fits_signed(i_imm, IMM6_W);
      end
      // Store data register sits in the rd slot
      OP_STR: begin
        o_insn = {OPC_STR, i_rt, i_rs, i_imm[5:0]};
        o_err  = !fits_signed(i_imm, IMM6_W);
      end
      OP_BR: begin
        o_insn = {OPC_BR, i_rd, i_imm[8:0]};
        o_err  = !fits_signed(i_imm, IMM9_W);
      end
      OP_NOP:  o_insn = 16'h0000;
      OP_JSR: begin
        o_insn = {OPC_JSR, i_imm[10:0]};
        o_err  = !fits_signed(i_imm, IMM11_W);
      end
      OP_JMP: begin
        o_insn = {OPC_JMP, i_imm[10:0]};
        o_err  = !fits_signed(i_imm, IMM11_W);
      end
      OP_JSRR: o_insn = {OPC_JSRR, 2'b00, i_rs, 6'b000000};
      OP_JMPR: o_insn = {OPC_JMPR, 2'b00, i_rs, 6'b000000};
      OP_RTI:  o_insn = INSN_RTI;
      OP_CONST: begin
        o_insn = {OPC_CONST, i_rd, i_imm[8:0]};
        o_err  = !fits_signed(i_imm, IMM9_W);
      end
      OP_HICONST: begin
        o_insn = {OPC_HICONST, i_rd, 1'b1, i_imm[7:0]};
        o_err  = !fits_unsigned(i_imm, IMM8_W);
      end
      OP_TRAP: begin
        o_insn = {OPC_TRAP, 4'b0000, i_imm[7:0]};
        o_err  = !fits_unsigned(i_imm, IMM8_W);
      end
      // LI first word: whole value if it fits simm9, else the sign-extended low byte
      OP_LI: begin
        if (fits_signed(i_imm, IMM9_W)) begin
          o_insn = {OPC_CONST, i_rd, i_imm[8:0]};
        end else begin
          o_insn = {OPC_CONST, i_rd, i_imm[7], i_imm[7:0]};
        end
      end
      default: begin
        o_insn = 16'h0000;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lc4_encoder.sv
// Streaming LC4 encoder: op records in, packed 16-bit words out; LI may expand to two words.
// Latency: 1 cycle from accepted record to out_insn; HICONST of a two-word LI follows one beat later.
// Backpressure: in_ready drops while a word is stalled or a HICONST is pending; output held stable.
module lc4_encoder
  import lc4_enc_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic [2:0]         in_rd,
  input  logic [2:0]         in_rs,
  input  logic [2:0]         in_rt,
  input  logic [15:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_insn,
  output logic               out_err,
  output logic [COUNT_W-1:0] word_count
);

  typedef enum logic {ST_IDLE, ST_HI_PEND} state_t;

  state_t             r_state;
  logic               r_out_vld;
  logic [15:0]        r_out_insn;
  logic               r_out_err;
  logic [15:0]        r_hi_insn;
  logic [COUNT_W-1:0] r_count;

  op_t         w_op;
  logic [15:0] w_pk_insn;
  logic        w_pk_err;
  logic        w_take;
  logic        w_acc;
  logic        w_li_two;
  logic [15:0] w_hi_insn;

  assign w_op = op_t'(in_op);

  lc4_field_pack u_pack (
    .i_op   (w_op),
    .i_rd   (in_rd),
    .i_rs   (in_rs),
    .i_rt   (in_rt),
    .i_imm  (in_imm),
    .o_insn (w_pk_insn),
    .o_err  (w_pk_err)
  );

  // Ready depends only on registered state and out_ready, so no in_valid->out path exists
  assign in_ready  = !rst && (r_state == ST_IDLE) && (!r_out_vld || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_take    = r_out_vld && out_ready;
  assign w_li_two  = (w_op == OP_LI) && !fits_signed(in_imm, IMM9_W);
  assign w_hi_insn = {OPC_HICONST, in_rd, 1'b1, in_imm[15:8]};

  // Output register, LI expansion FSM and accepted-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_out_vld  <= 1'b0;
      r_out_insn <= 16'h0000;
      r_out_err  <= 1'b0;
      r_hi_insn  <= 16'h0000;
      r_count    <= '0;
    end else begin
      if (w_take) begin
        r_count <= r_count + COUNT_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_out_vld  <= 1'b1;
            r_out_insn <= w_pk_insn;
            r_out_err  <= w_pk_err;
            if (w_li_two) begin
              r_hi_insn <= w_hi_insn;
              r_state   <= ST_HI_PEND;
            end
          end else if (w_take) begin
            r_out_vld <= 1'b0;
          end
        end
        ST_HI_PEND: begin
          // CONST word is presented; swap in HICONST once it is consumed
          if (w_take) begin
            r_out_insn <= r_hi_insn;
            r_out_err  <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_vld;
  assign out_insn   = r_out_insn;
  assign out_err    = r_out_err;
  assign word_count = r_count;

endmodule

// File: tb/tb_lc4_encoder.sv
// Scoreboard bench for lc4_encoder: directed records with hand-computed words.
// Latency: expectations queued at issue, popped by a monitor at each output transfer.
// Backpressure: out_ready is toggled to exercise stalls and the two-word LI path.
module tb_lc4_encoder;
  import lc4_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = 5'd0;
  logic [2:0]  in_rd = 3'd0;
  logic [2:0]  in_rs = 3'd0;
  logic [2:0]  in_rt = 3'd0;
  logic [15:0] in_imm = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_insn;
  logic        out_err;
  logic [15:0] word_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic [16:0] exp_q[$];
  bit          stall_seen = 1'b0;
  logic [15:0] stall_insn;
  logic        stall_err;

  lc4_encoder #(.COUNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_insn   (out_insn),
    .out_err    (out_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic expw(input logic [15:0] w, input logic e);
    exp_q.push_back({e, w});
  endtask

  // Present a record and hold it until accepted (called just after a rising edge)
  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [15:0] imm);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each transferred word against the scoreboard, and check stall stability
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      n_xfer = 0;
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) begin
        chk("hold_insn", out_insn, stall_insn);
        chk("hold_err", out_err, stall_err);
      end
      stall_seen = out_valid && !out_ready;
      stall_insn = out_insn;
      stall_err  = out_err;
      if (out_valid && out_ready) begin
        chk("word_count_tally", word_count, n_xfer[15:0]);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%04h, expected no word", out_insn);
        end else begin
          e = exp_q.pop_front();
          chk("insn", out_insn, e[15:0]);
          chk("err", out_err, e[16]);
        end
        n_xfer++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_insn", out_insn, 16'h0000);
    chk("rst_out_err", out_err, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    expw(16'h1283, 1'b0); send(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000);
    drain();
    chk("wc_after_add", word_count, 1);

    // Two-word LI: in_ready low while CONST is presented, high once HICONST is loaded
    expw(16'h9634, 1'b0); expw(16'hD712, 1'b0);
    send(OP_LI, 3'd3, 3'd0, 3'd0, 16'h1234);
    @(negedge clk); chk("in_ready_const_beat", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("in_ready_hi_beat", in_ready, 1);
    @(posedge clk); #1;

    expw(16'h95FB, 1'b0); send(OP_LI,      3'd2, 3'd0, 3'd0, 16'hFFFB);
    expw(16'h1270, 1'b1); send(OP_ADDI,    3'd1, 3'd1, 3'd0, 16'd16);
    expw(16'h1270, 1'b0); send(OP_ADDI,    3'd1, 3'd1, 3'd0, 16'hFFF0);
    expw(16'hF025, 1'b0); send(OP_TRAP,    3'd0, 3'd0, 3'd0, 16'h0025);
    expw(16'h297F, 1'b0); send(OP_CMPI,    3'd0, 3'd4, 3'd0, 16'hFFFF);
    expw(16'hA285, 1'b0); send(OP_SLL,     3'd1, 3'd2, 3'd0, 16'd5);
    expw(16'h0FFE, 1'b0); send(OP_BR,      3'd7, 3'd0, 3'd0, 16'hFFFE);
    expw(16'h4140, 1'b0); send(OP_JSRR,    3'd0, 3'd5, 3'd0, 16'h0000);
    expw(16'h75BF, 1'b0); send(OP_STR,     3'd0, 3'd6, 3'd2, 16'hFFFF);
    expw(16'hD3FF, 1'b1); send(OP_HICONST, 3'd1, 3'd0, 3'd0, 16'h01FF);
    expw(16'h0000, 1'b1); send(5'd31,      3'd1, 3'd2, 3'd3, 16'h0000);
    expw(16'h8000, 1'b0); send(OP_RTI,     3'd0, 3'd0, 3'd0, 16'h0000);
    drain();
    chk("wc_after_batch", word_count, 15);

    // Stall: word held, in_ready low for 3 cycles, then the next record goes straight in
    expw(16'h1283, 1'b0); expw(16'h1956, 1'b0);
    send(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_insn", out_insn, 16'h1283);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(OP_SUB, 3'd4, 3'd5, 3'd6, 16'h0000);
    drain();
    chk("wc_after_stall", word_count, 17);

    // Reset while HICONST is pending: it must never be emitted
    expw(16'h9634, 1'b0);
    send(OP_LI, 3'd3, 3'd0, 3'd0, 16'h1234);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hi_pending_insn", out_insn, 16'hD712);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_word_count", word_count, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
